load_data_collector: RTL and testbench

- Stage directly downstream of the index-to-load-command converter.
- Consumes the DataMover MM2S read-data stream and status stream produced for each 8-byte load command.
- Delivers one 64-bit value per command through a registered 2-entry skid buffer.
- Tracks outstanding commands and issues credit to the command stage; checks DataMover status and stream framing, and reports sticky errors.

---
 rtl/load_data_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_load_data_collector.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_data_collector.sv
// load_data_collector
// Collects the DataMover MM2S read-data and status streams produced for each
// 8-byte load command. Values leave through a registered 2-entry skid buffer,
// outstanding commands are counted to issue credit upstream, and status and
// stream-framing problems are latched into sticky error registers.
//
// Handshake semantics (every valid/ready pair in this block):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A source holding valid high keeps its payload stable until that edge;
//   valid never depends combinationally on ready. All ready/valid outputs of
//   this block are driven straight from flops.
//
// CNT_W must satisfy 2**CNT_W > MAX_OUTSTANDING so that the saturated count
// MAX_OUTSTANDING is representable.

module load_data_collector #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             io_cmdFire,
    output logic             io_cmdAllow,

    input  logic             io_dataIn_valid,
    output logic             io_dataIn_ready,
    input  logic [63:0]      io_dataIn_bits,
    input  logic             io_dataIn_last,

    input  logic             io_statusIn_valid,
    output logic             io_statusIn_ready,
    input  logic [7:0]       io_statusIn_bits,

    output logic             io_valueOut_valid,
    input  logic             io_valueOut_ready,
    output logic [63:0]      io_valueOut_bits,

    output logic [CNT_W-1:0] io_outstanding,
    output logic [31:0]      io_beatCount,
    output logic             io_error,
    output logic [2:0]       io_errorCode,
    output logic [7:0]       io_errorStatus,
    input  logic             io_clearError,
    output logic             io_idle
);

    // Saturation limit expressed in the counter's own width.
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // Error code bit positions.
    localparam int ERR_BAD_STATUS = 0;
    localparam int ERR_NO_LAST    = 1;
    localparam int ERR_UNEXP_STAT = 2;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // out_*  : the entry presented on valueOut (registered output).
    // skid_* : the second entry, only ever occupied while out_* is occupied
    //          and stalled. Buffer full <=> skid entry occupied.
    logic             out_valid_q,  out_valid_d;
    logic [63:0]      out_data_q,   out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [63:0]      skid_data_q,  skid_data_d;

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [31:0]      beat_count_q,  beat_count_d;
    logic [2:0]       error_code_q,  error_code_d;
    logic [7:0]       error_status_q, error_status_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic in_fire;
    logic out_fire;
    logic status_fire;
    logic status_bad;
    logic cnt_zero;
    logic cnt_full;

    // Decode transfers and status quality from current inputs and state.
    always_comb begin
        in_fire     = io_dataIn_valid & ~skid_valid_q;
        out_fire    = out_valid_q & io_valueOut_ready;
        // Status is always accepted, so valid alone is the handshake.
        status_fire = io_statusIn_valid;
        // OKAY must be set and none of SLVERR/DECERR/INTERR may be set.
        status_bad  = ~io_statusIn_bits[7] | (|io_statusIn_bits[6:4]);
        cnt_zero    = (outstanding_q == '0);
        cnt_full    = (outstanding_q >= MAX_CNT);
    end

    // ------------------------------------------------------------------
    // Skid buffer next state
    // ------------------------------------------------------------------
    // Output slot refills from the skid slot first (order preservation),
    // otherwise straight from the input; a stalled output parks the new beat
    // in the skid slot. The skid slot is only loaded while not full, so a
    // skid-to-output move never coincides with a new input beat.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = io_dataIn_bits;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = io_dataIn_bits;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding command counter next state
    // ------------------------------------------------------------------
    // Increment on cmdFire, decrement on status. Simultaneous events cancel.
    // A cmdFire while already at the limit saturates; a lone status at zero
    // holds at zero (reported separately as an unexpected status).
    always_comb begin
        outstanding_d = outstanding_q;
        case ({io_cmdFire, status_fire})
            2'b10: begin
                if (!cnt_full) begin
                    outstanding_d = outstanding_q + 1'b1;
                end
            end
            2'b01: begin
                if (!cnt_zero) begin
                    outstanding_d = outstanding_q - 1'b1;
                end
            end
            default: begin
                outstanding_d = outstanding_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Delivered-value counter next state (wraps naturally at 2^32)
    // ------------------------------------------------------------------
    // Count every value handed off on valueOut.
    always_comb begin
        beat_count_d = beat_count_q;
        if (out_fire) begin
            beat_count_d = beat_count_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error register next state
    // ------------------------------------------------------------------
    // New events OR into the code; the status byte is captured only for the
    // first bad status since the last clear. A clear in the same cycle as a
    // new event wins and the event is discarded.
    always_comb begin
        logic [2:0] new_err;

        new_err                 = 3'b000;
        new_err[ERR_BAD_STATUS] = status_fire & status_bad;
        new_err[ERR_NO_LAST]    = in_fire & ~io_dataIn_last;
        new_err[ERR_UNEXP_STAT] = status_fire & ~io_cmdFire & cnt_zero;

        error_code_d   = error_code_q;
        error_status_d = error_status_q;

        if (io_clearError) begin
            error_code_d   = 3'b000;
            error_status_d = 8'h00;
        end else begin
            error_code_d = error_code_q | new_err;
            if (new_err[ERR_BAD_STATUS] && !error_code_q[ERR_BAD_STATUS]) begin
                error_status_d = io_statusIn_bits;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Synchronous reset flushes the buffer and zeroes counters and errors;
    // any beats held at that moment are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= 64'd0;
            skid_valid_q   <= 1'b0;
            skid_data_q    <= 64'd0;
            outstanding_q  <= '0;
            beat_count_q   <= 32'd0;
            error_code_q   <= 3'b000;
            error_status_q <= 8'h00;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            skid_valid_q   <= skid_valid_d;
            skid_data_q    <= skid_data_d;
            outstanding_q  <= outstanding_d;
            beat_count_q   <= beat_count_d;
            error_code_q   <= error_code_d;
            error_status_q <= error_status_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // All outputs are decoded from registers only.
    always_comb begin
        io_cmdAllow       = ~cnt_full;
        io_dataIn_ready   = ~skid_valid_q;
        io_statusIn_ready = 1'b1;
        io_valueOut_valid = out_valid_q;
        io_valueOut_bits  = out_data_q;
        io_outstanding    = outstanding_q;
        io_beatCount      = beat_count_q;
        io_error          = |error_code_q;
        io_errorCode      = error_code_q;
        io_errorStatus    = error_status_q;
        io_idle           = cnt_zero & ~out_valid_q & ~skid_valid_q;
    end

endmodule

// File: tb/tb_load_data_collector.sv
// Directed testbench for load_data_collector.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// either 1 time unit after the edge or on the falling edge.

module tb_load_data_collector;

    localparam int CNT_W = 5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic             cmd_fire = 1'b0;
    logic             cmd_allow;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [63:0]      din_bits = 64'd0;
    logic             din_last = 1'b1;
    logic             st_valid = 1'b0;
    logic             st_ready;
    logic [7:0]       st_bits = 8'h00;
    logic             vout_valid;
    logic             vout_ready = 1'b0;
    logic [63:0]      vout_bits;
    logic [CNT_W-1:0] outstanding;
    logic [31:0]      beat_count;
    logic             error;
    logic [2:0]       error_code;
    logic [7:0]       error_status;
    logic             clear_error = 1'b0;
    logic             idle;

    load_data_collector #(
        .MAX_OUTSTANDING(16),
        .CNT_W(CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .io_cmdFire        (cmd_fire),
        .io_cmdAllow       (cmd_allow),
        .io_dataIn_valid   (din_valid),
        .io_dataIn_ready   (din_ready),
        .io_dataIn_bits    (din_bits),
        .io_dataIn_last    (din_last),
        .io_statusIn_valid (st_valid),
        .io_statusIn_ready (st_ready),
        .io_statusIn_bits  (st_bits),
        .io_valueOut_valid (vout_valid),
        .io_valueOut_ready (vout_ready),
        .io_valueOut_bits  (vout_bits),
        .io_outstanding    (outstanding),
        .io_beatCount      (beat_count),
        .io_error          (error),
        .io_errorCode      (error_code),
        .io_errorStatus    (error_status),
        .io_clearError     (clear_error),
        .io_idle           (idle)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    int          exp_beats = 0;

    // Every value handed off on valueOut must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && vout_valid && vout_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_value: got %h, none expected", vout_bits);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (vout_bits !== e) begin
                    n_err++;
                    $display("FAIL sb_value: got %h, expected %h", vout_bits, e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_value(input logic [63:0] v);
        exp_q.push_back(v);
        exp_beats++;
    endtask

    task automatic fire_cmds(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_fire = 1'b1;
            tick();
        end
        cmd_fire = 1'b0;
    endtask

    task automatic send_status(input logic [7:0] s, input int n);
        st_bits = s;
        for (int i = 0; i < n; i++) begin
            st_valid = 1'b1;
            tick();
        end
        st_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (cmd_allow !== 1'b1) begin n_err++; $display("FAIL reset_cmd_allow: got %b, expected 1", cmd_allow); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b, expected 1", idle); end
        n_vec++; if (vout_valid !== 1'b0) begin n_err++; $display("FAIL reset_vout_valid: got %b, expected 0", vout_valid); end
        n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d, expected 0", outstanding); end
        n_vec++; if (beat_count !== 32'd0) begin n_err++; $display("FAIL reset_beat_count: got %0d, expected 0", beat_count); end
        n_vec++; if ({error, error_code, error_status} !== 12'h000) begin n_err++; $display("FAIL reset_errors: got %b/%b/%h, expected 0/000/00", error, error_code, error_status); end
        n_vec++; if (din_ready !== 1'b1 || st_ready !== 1'b1) begin n_err++; $display("FAIL reset_readies: got din %b st %b, expected 1 1", din_ready, st_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] vals [3];
        vals = '{64'h11, 64'h22, 64'h33};
        vout_ready = 1'b1;
        fire_cmds(3);
        n_vec++; if (outstanding !== 5'd3) begin n_err++; $display("FAIL basic_outstanding3: got %0d, expected 3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din_bits  = vals[i];
            din_last  = 1'b1;
            expect_value(vals[i]);
            tick();
            n_vec++;
            if (vout_valid !== 1'b1 || vout_bits !== vals[i]) begin
                n_err++;
                $display("FAIL basic_latency: got valid %b bits %h, expected 1 %h", vout_valid, vout_bits, vals[i]);
            end
        end
        din_valid = 1'b0;
        send_status(8'h80, 3);
        wait_drain();
        @(negedge clk);
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_drain: got %0d pending, expected 0", exp_q.size()); end
        n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL basic_outstanding0: got %0d, expected 0", outstanding); end
        n_vec++; if (beat_count !== 32'd3) begin n_err++; $display("FAIL basic_beat_count: got %0d, expected 3", beat_count); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL basic_error: got %b, expected 0", error); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL basic_idle: got %b, expected 1", idle); end
    endtask

    task automatic test_backpressure();
        vout_ready = 1'b0;
        din_valid  = 1'b1;
        din_last   = 1'b1;
        din_bits   = 64'hA;
        expect_value(64'hA);
        tick();
        n_vec++; if (din_ready !== 1'b1 || vout_bits !== 64'hA) begin n_err++; $display("FAIL bp_first: got ready %b bits %h, expected 1 a", din_ready, vout_bits); end
        din_bits = 64'hB;
        expect_value(64'hB);
        tick();
        n_vec++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got ready %b, expected 0", din_ready); end
        din_bits = 64'hC;
        expect_value(64'hC);
        tick();
        n_vec++; if (din_ready !== 1'b0 || vout_valid !== 1'b1 || vout_bits !== 64'hA) begin n_err++; $display("FAIL bp_hold: got ready %b valid %b bits %h, expected 0 1 a", din_ready, vout_valid, vout_bits); end
        vout_ready = 1'b1;
        tick();
        n_vec++; if (vout_bits !== 64'hB || din_ready !== 1'b1) begin n_err++; $display("FAIL bp_second: got bits %h ready %b, expected b 1", vout_bits, din_ready); end
        tick();
        din_valid = 1'b0;
        n_vec++; if (vout_bits !== 64'hC) begin n_err++; $display("FAIL bp_third: got %h, expected c", vout_bits); end
        wait_drain();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [4];
        vals = '{64'hDEAD_0001, 64'hBEEF_0002, 64'hCAFE_0003, 64'hF00D_0004};
        vout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1;
            din_bits  = vals[i];
            din_last  = 1'b1;
            expect_value(vals[i]);
            tick();
            n_vec++;
            if (din_ready !== 1'b1 || vout_bits !== vals[i]) begin
                n_err++;
                $display("FAIL b2b_stream: got ready %b bits %h, expected 1 %h", din_ready, vout_bits, vals[i]);
            end
        end
        din_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        n_vec++; if (beat_count !== 32'(exp_beats)) begin n_err++; $display("FAIL b2b_beat_count: got %0d, expected %0d", beat_count, exp_beats); end
    endtask

    task automatic test_credit();
        fire_cmds(16);
        n_vec++; if (outstanding !== 5'd16 || cmd_allow !== 1'b0) begin n_err++; $display("FAIL credit_full: got %0d allow %b, expected 16 0", outstanding, cmd_allow); end
        fire_cmds(1);
        n_vec++; if (outstanding !== 5'd16) begin n_err++; $display("FAIL credit_saturate: got %0d, expected 16", outstanding); end
        cmd_fire = 1'b1;
        send_status(8'h80, 1);
        cmd_fire = 1'b0;
        n_vec++; if (outstanding !== 5'd16) begin n_err++; $display("FAIL credit_both: got %0d, expected 16", outstanding); end
        send_status(8'h80, 1);
        n_vec++; if (outstanding !== 5'd15 || cmd_allow !== 1'b1) begin n_err++; $display("FAIL credit_release: got %0d allow %b, expected 15 1", outstanding, cmd_allow); end
        send_status(8'h80, 15);
        n_vec++; if (outstanding !== 5'd0 || error !== 1'b0) begin n_err++; $display("FAIL credit_drain: got %0d err %b, expected 0 0", outstanding, error); end
        // Status and command together at zero: balanced, not unexpected.
        cmd_fire = 1'b1;
        send_status(8'h80, 1);
        cmd_fire = 1'b0;
        n_vec++; if (outstanding !== 5'd0 || error !== 1'b0) begin n_err++; $display("FAIL credit_zero_both: got %0d err %b, expected 0 0", outstanding, error); end
    endtask

    task automatic test_status_errors();
        fire_cmds(2);
        send_status(8'h40, 1);
        send_status(8'h20, 1);
        n_vec++; if (error !== 1'b1 || error_code !== 3'b001) begin n_err++; $display("FAIL stat_code: got %b %b, expected 1 001", error, error_code); end
        n_vec++; if (error_status !== 8'h40) begin n_err++; $display("FAIL stat_first_wins: got %h, expected 40", error_status); end
        n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL stat_outstanding: got %0d, expected 0", outstanding); end
        clear_error = 1'b1;
        send_status(8'h20, 1);
        clear_error = 1'b0;
        n_vec++; if ({error, error_code, error_status} !== 12'h000) begin n_err++; $display("FAIL stat_clear_wins: got %b/%b/%h, expected 0/000/00", error, error_code, error_status); end
        // OKAY together with INTERR still counts as bad.
        fire_cmds(1);
        send_status(8'h93, 1);
        n_vec++; if (error_code !== 3'b001 || error_status !== 8'h93) begin n_err++; $display("FAIL stat_interr: got %b %h, expected 001 93", error_code, error_status); end
        pulse_clear();
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL stat_clear: got %b, expected 0", error); end
    endtask

    task automatic test_unexpected_and_last();
        send_status(8'h80, 1);
        n_vec++; if (error_code !== 3'b100 || outstanding !== 5'd0) begin n_err++; $display("FAIL unexp_status: got %b %0d, expected 100 0", error_code, outstanding); end
        n_vec++; if (error_status !== 8'h00) begin n_err++; $display("FAIL unexp_err_status: got %h, expected 00", error_status); end
        pulse_clear();
        vout_ready = 1'b1;
        din_valid  = 1'b1;
        din_bits   = 64'h5A;
        din_last   = 1'b0;
        expect_value(64'h5A);
        tick();
        din_valid = 1'b0;
        din_last  = 1'b1;
        n_vec++; if (error_code !== 3'b010 || vout_valid !== 1'b1 || vout_bits !== 64'h5A) begin n_err++; $display("FAIL no_last: got code %b valid %b bits %h, expected 010 1 5a", error_code, vout_valid, vout_bits); end
        wait_drain();
        @(negedge clk);
        n_vec++; if (beat_count !== 32'(exp_beats)) begin n_err++; $display("FAIL no_last_count: got %0d, expected %0d", beat_count, exp_beats); end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        vout_ready = 1'b0;
        fire_cmds(5);
        din_valid = 1'b1;
        din_last  = 1'b1;
        din_bits  = 64'hD1;
        tick();
        din_bits  = 64'hD2;
        tick();
        din_valid = 1'b0;
        n_vec++; if (outstanding !== 5'd5 || vout_valid !== 1'b1 || din_ready !== 1'b0) begin n_err++; $display("FAIL mid_setup: got %0d valid %b ready %b, expected 5 1 0", outstanding, vout_valid, din_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_beats = 0;
        n_vec++; if (vout_valid !== 1'b0 || outstanding !== 5'd0) begin n_err++; $display("FAIL mid_flush: got valid %b outstanding %0d, expected 0 0", vout_valid, outstanding); end
        n_vec++; if (beat_count !== 32'd0 || idle !== 1'b1 || din_ready !== 1'b1) begin n_err++; $display("FAIL mid_state: got count %0d idle %b ready %b, expected 0 1 1", beat_count, idle, din_ready); end
        vout_ready = 1'b1;
        repeat (3) tick();
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_credit();
        test_status_errors();
        test_unexpected_and_last();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
